// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  localparam int MAX_WIDTH = 64;

  // Bit counter width; a 1-bit adder still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Gate-level full adder: two half adders plus an OR for the carry.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  wire p, g1, g2;

  xor u_x1 (p, a, b);
  and u_a1 (g1, a, b);
  xor u_x2 (s, p, ci);
  and u_a2 (g2, p, ci);
  or  u_o1 (co, g1, g2);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, with START/BUSY/DONE handshake.
// Optional subtract mode (SUB port) enabled by defining SERIAL_ADDER_SUB_EN.
//   state  | meaning
//   S_IDLE | waiting for start; sum/cout hold last result
//   S_RUN  | one result bit per clock through the FA cell
//   S_FIN  | done pulse; result valid
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_q, s_msb, sum_shift;
  logic             cout_q;
  logic             b_bit, s_bit, c_bit, carry_init, last_bit;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;

  // Subtract as A + ~B + 1; cin is ignored in this mode.
  assign b_bit      = b_sr[0] ^ sub_q;
  assign carry_init = sub ? 1'b1 : cin;
`else
  assign b_bit      = b_sr[0];
  assign carry_init = cin;
`endif

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_bit),
    .ci (carry),
    .s  (s_bit),
    .co (c_bit)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    s_msb            = '0;
    s_msb[WIDTH-1]   = s_bit;
    sum_shift        = (sum_sr >> 1) | s_msb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last_bit) state_nx = S_FIN;
      end
      S_FIN: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a_sr  <= a;
          b_sr  <= b;
          carry <= carry_init;
          cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
          sub_q <= sub;
`endif
        end
        S_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_shift;
          carry  <= c_bit;
          cnt    <= cnt + 1'b1;
          // Outputs load on the edge that enters FIN so they are valid with done.
          if (last_bit) begin
            sum_q  <= sum_shift;
            cout_q <= c_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, bit-serial successor to the gate-level half adder.
- Adds two WIDTH-bit operands LSB-first, one bit per clock, through a gate-level full-adder cell and a carry flip-flop.
- Uses a START/BUSY/DONE handshake, so arithmetic units can trade area for latency.
- Result and carry-out are held stable until the next accepted START.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  asynchronous, active-high reset.
START  input  1  request; sampled only in IDLE.
A  input  WIDTH  operand A; latched on accepted START.
B  input  WIDTH  operand B; latched on accepted START.
CIN  input  1  carry-in; latched on accepted START.
BUSY  output  1  high whenever state is not IDLE.
DONE  output  1  one-cycle pulse: SUM/COUT valid.
SUM  output  WIDTH  result; held until next accepted START.
COUT  output  1  final carry; held until next accepted START.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, bit counter=0, carry register=0.
  - Operand and sum shift registers = 0.
  - BUSY=0, DONE=0, SUM=0, COUT=0.
- States: IDLE, RUN, FIN.
- IDLE:
  - START=1 at an edge: latch A, B and CIN into the carry register; clear the counter; go to RUN.
  - START=0: stay in IDLE.
- RUN, each edge:
  - FA cell computes s,c from a_sr[0], b_sr[0], carry.
  - Shift operand registers right by 1.
  - Shift s into the MSB of sum_sr; carry<=c.
  - Counter +1.
  - When counter==WIDTH-1 at the edge: go to FIN.
- FIN: one cycle; DONE=1; SUM=sum_sr; COUT=carry. Next edge returns to IDLE.
- Latency:
  - START sampled at edge k gives DONE high in the cycle after edge k+WIDTH.
  - Back in IDLE after edge k+WIDTH+1.
  - Earliest next START is sampled at edge k+WIDTH+2, so throughput is 1 op per WIDTH+2 cycles.
- START while BUSY (RUN or FIN) is ignored; there is no queueing.
- A/B/CIN changes after acceptance have no effect.
- SUM/COUT are registered outputs:
  - Updated only on entry to FIN.
  - Hold their values through IDLE and the following RUN.
- Arithmetic: {COUT,SUM} = A + B + CIN, modulo 2^(WIDTH+1).
- Counter width is $clog2(WIDTH), with a minimum of 1.
- WIDTH=1: RUN lasts exactly one edge.
- RST mid-RUN: operation is aborted and all outputs return to reset values immediately, with no DONE pulse.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port SUB (1 bit), latched with the operands on START.
  - SUB=1 inverts B bits entering the FA and forces the initial carry to 1, ignoring CIN, giving SUM = A-B.
  - COUT=1 means no borrow.
  - SUB=0 gives normal add behaviour.
- Undefined: no SUB port; add only.

Decomposition:
- Package serial_adder_pkg:
  - state typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN}.
  - MAX_WIDTH=64 constant.
- Sub-module fa_cell: gate-level full adder built from two half adders plus an OR for carry, using primitive gates only. It is instantiated once in serial_adder.

Test Plan:
- WIDTH=8, A=8'h35, B=8'h4A, CIN=0, START pulse at edge 0 -> BUSY high from edge 0; DONE pulse after edge 8; SUM=8'h7F, COUT=0; held after DONE.
- WIDTH=8, A=8'hFF, B=8'h01, CIN=0 -> SUM=8'h00, COUT=1. Then A=8'hFF, B=8'h00, CIN=1 -> SUM=8'h00, COUT=1.
- Busy rejection:
  - START at edge 0 with A=8'h10, B=8'h20.
  - START again at edge 3 with A=8'hAA.
  - Expect a single DONE with SUM=8'h30 and no second DONE.
  - Next START is accepted only at edge 10 or later.
- Reset mid-operation:
  - Assert RST between edges 4 and 5 of a RUN.
  - Expect BUSY=0, SUM=0, COUT=0 asynchronously, and no DONE.
  - A following START with 8'h01+8'h01 gives SUM=8'h02.
- WIDTH=1 instance: A=1, B=1, CIN=0 -> DONE after edge 1, SUM=0, COUT=1.
- With SERIAL_ADDER_SUB_EN:
  - SUB=1, 8'h10-8'h01 -> SUM=8'h0F, COUT=1.
  - SUB=1, 8'h01-8'h02 -> SUM=8'hFF, COUT=0.
